// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Sklansky prefix adder.
package prefix_adder_pkg;

  // Generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2 for elaboration-time sizing (arguments 2..64).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Prefix operator: hi is the more significant group, lo the adjacent lower one.
  function automatic gp_t gp_comb(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// One registered Sklansky prefix level; h and c0 ride along untouched.
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 1
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  gp_t [WIDTH-1:0]       i_gp,
  input  logic [WIDTH-1:0]      i_h,
  input  logic                  i_c0,
  output gp_t [WIDTH-1:0]       o_gp,
  output logic [WIDTH-1:0]      o_h,
  output logic                  o_c0
);

  gp_t [WIDTH-1:0] w_gp;

  // Bits with bit (K-1) set absorb the group ending just below their 2^(K-1)-aligned block.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (((i >> (K-1)) & 1) == 1) begin : g_comb
      localparam int J = ((i >> (K-1)) << (K-1)) - 1;
      assign w_gp[i] = gp_comb(i_gp[i], i_gp[J]);
    end else begin : g_pass
      assign w_gp[i] = i_gp[i];
    end
  end

  // Stage register, frozen with the rest of the pipe when the output stalls.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_gp <= w_gp;
      o_h  <= i_h;
      o_c0 <= i_c0;
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky adder/subtractor: operand stage, LEVELS prefix stages,
// sum stage. One global enable stalls the whole pipe from the output side.
module prefix_adder_pipe
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int LAT    = LEVELS + 2;

  logic                 w_en;
  logic [WIDTH-1:0]     w_y;
  logic                 w_c0;
  gp_t  [WIDTH-1:0]     w_gp_in;
  logic [WIDTH-1:0]     w_gl;
  logic [LAT-1:0]       r_vld_pipe;

  gp_t  [WIDTH-1:0]     r_gp0;
  logic [WIDTH-1:0]     r_h0;
  logic                 r_c0;

  gp_t  [WIDTH-1:0]     w_gp [LEVELS+1];
  logic [WIDTH-1:0]     w_h  [LEVELS+1];
  logic                 w_cc [LEVELS+1];

  assign w_en      = ~out_valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[LAT-1];
  assign w_y       = sub ? ~y : y;
  assign w_c0      = sub | cin;

  // Bit 0 absorbs the carry-in as a virtual bit -1 (g=c0, p=0), so every
  // final G[i] is the true carry into bit i+1 with no extra prefix level.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_gp_in[i].g = x[i] & w_y[i];
      w_gp_in[i].p = x[i] | w_y[i];
    end
    w_gp_in[0].g = (x[0] & w_y[0]) | ((x[0] | w_y[0]) & w_c0);
    w_gp_in[0].p = 1'b0;
  end

  // Operand stage: per-bit generate/propagate/xor plus effective carry-in.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_gp0 <= w_gp_in;
      r_h0  <= x ^ w_y;
      r_c0  <= w_c0;
    end
  end

  assign w_gp[0] = r_gp0;
  assign w_h[0]  = r_h0;
  assign w_cc[0] = r_c0;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    prefix_level #(.WIDTH(WIDTH), .K(k)) u_lvl (
      .clk  (clk),
      .i_en (w_en),
      .i_gp (w_gp[k-1]),
      .i_h  (w_h[k-1]),
      .i_c0 (w_cc[k-1]),
      .o_gp (w_gp[k]),
      .o_h  (w_h[k]),
      .o_c0 (w_cc[k])
    );
  end

  // Group generates out of the last level are the carries.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) w_gl[i] = w_gp[LEVELS][i].g;
  end

  // Sum stage: carry into bit i is c0 for bit 0, else G[i-1].
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_en) begin
      s    <= w_h[LEVELS] ^ {w_gl[WIDTH-2:0], w_cc[LEVELS]};
      cout <= w_gl[WIDTH-1];
      ovf  <= w_gl[WIDTH-1] ^ w_gl[WIDTH-2];
    end
  end

  // Valid shift register; bubbles travel as zeros, everything holds on stall.
  always_ff @(posedge clk) begin
    if (rst)       r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= {r_vld_pipe[LAT-2:0], in_valid};
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: a 16-bit instance for directed, streaming,
// stall and reset checks, and a 6-bit instance swept exhaustively.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic rst;
  // 16-bit instance
  logic        iv_a, ir_a, ci_a, sb_a, ov_a, or_a, co_a, of_a;
  logic [15:0] x_a, y_a, s_a;
  // 6-bit instance
  logic        iv_b, ir_b, ci_b, sb_b, ov_b, or_b, co_b, of_b;
  logic [5:0]  x_b, y_b, s_b;

  longint q_a[$];
  longint q_b[$];
  int     res_a = 0;
  int     res_b = 0;
  bit     rnd_done;

  prefix_adder_pipe #(.WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .x(x_a), .y(y_a),
    .cin(ci_a), .sub(sb_a), .out_valid(ov_a), .out_ready(or_a), .s(s_a),
    .cout(co_a), .ovf(of_a));

  prefix_adder_pipe #(.WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .x(x_b), .y(y_b),
    .cin(ci_b), .sub(sb_b), .out_valid(ov_b), .out_ready(or_b), .s(s_b),
    .cout(co_b), .ovf(of_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, packed as {ovf, cout, s}.
  function automatic longint ref_add(input int w, input longint a, input longint b,
                                     input bit c, input bit sb);
    longint mask, ua, ub, sum, sa, sv, r, lo, hi;
    bit co, ov;
    mask = (longint'(1) << w) - 1;
    ua   = a & mask;
    ub   = b & mask;
    sum  = ua + (sb ? (~ub & mask) : ub) + (sb ? 1 : longint'(c));
    co   = ((sum >> w) & 1) != 0;
    sa   = (ua >= (longint'(1) << (w-1))) ? ua - (longint'(1) << w) : ua;
    sv   = (ub >= (longint'(1) << (w-1))) ? ub - (longint'(1) << w) : ub;
    r    = sb ? sa - sv : sa + sv + longint'(c);
    lo   = -(longint'(1) << (w-1));
    hi   = (longint'(1) << (w-1)) - 1;
    ov   = (r < lo) || (r > hi);
    return (longint'(ov) << (w+1)) | (longint'(co) << w) | (sum & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard and stall-stability monitors, sampled mid-cycle.
  logic        pst_a, pst_b;
  logic [17:0] prv_a;
  logic [7:0]  prv_b;
  longint      e_a, e_b;

  always @(negedge clk) begin
    if (rst) pst_a = 1'b0;
    else begin
      if (pst_a) chk("stall_hold_a", {ov_a, of_a, co_a, s_a}, {1'b1, prv_a});
      if (ov_a && !or_a) chk("stall_rdy_a", ir_a, 0);
      if (ov_a && or_a) begin
        if (q_a.size() == 0) chk("unexpected_a", 1, 0);
        else begin
          e_a = q_a.pop_front();
          chk("result_a", {of_a, co_a, s_a}, e_a);
          res_a++;
        end
      end
      pst_a = ov_a && !or_a;
      prv_a = {of_a, co_a, s_a};
    end
  end

  always @(negedge clk) begin
    if (rst) pst_b = 1'b0;
    else begin
      if (pst_b) chk("stall_hold_b", {ov_b, of_b, co_b, s_b}, {1'b1, prv_b});
      if (ov_b && or_b) begin
        if (q_b.size() == 0) chk("unexpected_b", 1, 0);
        else begin
          e_b = q_b.pop_front();
          chk("result_b", {of_b, co_b, s_b}, e_b);
          res_b++;
        end
      end
      pst_b = ov_b && !or_b;
      prv_b = {of_b, co_b, s_b};
    end
  end

  task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    int n;
    bit acc;
    n = 0; acc = 0;
    x_a = a; y_a = b; ci_a = c; sb_a = sb; iv_a = 1'b1;
    while (!acc && n < 50) begin
      #1 acc = ir_a;
      tick();
      n++;
    end
    iv_a = 1'b0;
    if (!acc) chk("send_timeout_a", 0, 1);
    else q_a.push_back(ref_add(16, longint'(a), longint'(b), c, sb));
  endtask

  task automatic send_b(input logic [5:0] a, input logic [5:0] b, input logic c, input logic sb);
    int n;
    bit acc;
    n = 0; acc = 0;
    x_b = a; y_b = b; ci_b = c; sb_b = sb; iv_b = 1'b1;
    while (!acc && n < 50) begin
      #1 acc = ir_b;
      tick();
      n++;
    end
    iv_b = 1'b0;
    if (!acc) chk("send_timeout_b", 0, 1);
    else q_b.push_back(ref_add(6, longint'(a), longint'(b), c, sb));
  endtask

  // Counts edges from the accepting edge (edge 1) to the one raising out_valid.
  task automatic lat_a(input int expl);
    int k;
    k = 1;
    while (!ov_a && k < 20) begin tick(); k++; end
    chk("latency_a", k, expl);
  endtask

  task automatic lat_b(input int expl);
    int k;
    k = 1;
    while (!ov_b && k < 20) begin tick(); k++; end
    chk("latency_b", k, expl);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin tick(); n++; end
    if (q_a.size() != 0 || q_b.size() != 0) chk("drain_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iv_a = 0; x_a = 0; y_a = 0; ci_a = 0; sb_a = 0; or_a = 1;
    iv_b = 0; x_b = 0; y_b = 0; ci_b = 0; sb_b = 0; or_b = 1;
    tick(); tick();

    chk("rst_ov_a", ov_a, 0);
    chk("rst_out_a", {of_a, co_a, s_a}, 0);
    chk("rst_ov_b", ov_b, 0);
    rst = 1'b0;
    chk("rdy_after_rst", ir_a, 1);

    // Directed corner cases with latency.
    send_a(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    lat_a(6);
    chk("wrap_ffff_p1", {of_a, co_a, s_a}, {1'b0, 1'b1, 16'h0000});
    drain();
    send_a(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    lat_a(6);
    chk("ovf_7fff_p1", {of_a, co_a, s_a}, {1'b1, 1'b0, 16'h8000});
    drain();
    send_a(16'h0005, 16'h0007, 1'b1, 1'b1);
    lat_a(6);
    chk("sub_5_m7", {of_a, co_a, s_a}, {1'b0, 1'b0, 16'hFFFE});
    drain();
    send_b(6'h3F, 6'h01, 1'b0, 1'b0);
    lat_b(5);
    chk("wrap_b", {of_b, co_b, s_b}, {1'b0, 1'b1, 6'h00});
    drain();

    // Back-to-back stream with a 3-cycle output stall mid-stream.
    res_a = 0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (10) tick();
        or_a = 1'b0;
        repeat (3) tick();
        or_a = 1'b1;
      end
    join
    drain();
    chk("stream_count", res_a, 20);

    // Random out_ready pressure for ordering and no loss/duplication.
    res_a = 0;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++)
          send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          or_a = 1'($urandom_range(0, 1));
          tick();
        end
        or_a = 1'b1;
      end
    join
    drain();
    chk("random_count", res_a, 200);

    // Reset with four operands in flight: none may emerge.
    for (int i = 0; i < 4; i++) send_a(16'(i + 1), 16'h1000, 1'b0, 1'b0);
    rst = 1'b1;
    q_a.delete();
    tick();
    rst = 1'b0;
    chk("flush_ov", ov_a, 0);
    chk("flush_out", {of_a, co_a, s_a}, 0);
    chk("flush_rdy", ir_a, 1);
    send_a(16'h1234, 16'h4321, 1'b1, 1'b0);
    lat_a(6);
    chk("post_rst_val", {of_a, co_a, s_a}, {1'b0, 1'b0, 16'h5556});
    drain();
    repeat (8) tick();

    // Exhaustive 6-bit sweep.
    res_b = 0;
    for (int xi = 0; xi < 64; xi++)
      for (int yi = 0; yi < 64; yi++)
        for (int m = 0; m < 4; m++)
          send_b(6'(xi), 6'(yi), m[0], m[1]);
    drain();
    chk("exhaustive_count", res_b, 16384);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
